instruction_encoder: RTL and testbench
======================================

INSTRUCTION_ENCODER -- requirements
Module: instruction_encoder

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk (input, 1, rising-edge clock) and reset (input, 1, synchronous active-high reset).
REQ-002 The block SHALL have the port in_valid (input, 1): source offers a field set.
REQ-003 The block SHALL have the port in_ready (output, 1): block accepts the field set this cycle.
REQ-004 The block SHALL have the port opcode (input, 7): opcode; bits [6:5] select the format.
REQ-005 The block SHALL have the ports rd, rs1 and rs2 (inputs, 5 each): register indices.
REQ-006 The block SHALL have the port funct3 (input, 3): function field.
REQ-007 The block SHALL have the port imm (input, 64): sign-extended immediate; for branches it is the offset in halfword units.
REQ-008 The block SHALL have the port out_valid (output, 1): instruction word available.
REQ-009 The block SHALL have the port out_ready (input, 1): sink takes the word.
REQ-010 The block SHALL have the port instruction (output, 32): encoded instruction word.
REQ-011 The block SHALL have the port count (output, 16): number of words delivered.
REQ-012 The block SHALL have the port imm_err (output, 1): one-cycle pulse when a field set is rejected for immediate range.

Function
REQ-013 Format by opcode[6:5]: 00 = I (load), 01 = S (store), 1x = SB (branch).
REQ-014 I format: instruction = {imm[11:0], rs1, funct3, rd, opcode}.
REQ-015 S format: instruction = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}.
REQ-016 SB format: instruction = {imm[11], imm[9:4], rs2, rs1, funct3, imm[3:0], imm[10], opcode}; rd is ignored.
REQ-017 Round-trip property: re-extracting the 12-bit immediate from the word and sign-extending it to 64 bits SHALL equal imm for every in-range input.
REQ-018 Accept occurs on a rising edge where in_valid=1 and in_ready=1; the encoded word is written into a 2-entry FIFO.
REQ-019 in_ready = 1 when the FIFO holds fewer than 2 entries; it is a function of registered state only.
REQ-020 out_valid = 1 when the FIFO is non-empty; instruction = the head entry; a pop occurs on an edge where out_valid=1 and out_ready=1.
REQ-021 Latency: a word accepted at edge N is presented at the output from edge N onward (visible the following cycle), with no combinational path from in_* to out_*.
REQ-022 Simultaneous push and pop with 1 entry held: occupancy stays 1 and order is preserved.
REQ-023 Full FIFO with a pop: in_ready stays 0 this cycle and rises the next cycle.
REQ-024 instruction holds its last value while out_valid=0 and is don't-care for checking.
REQ-025 count increments by 1 on each pop and wraps from 0xFFFF to 0x0000.
REQ-026 Output order SHALL equal acceptance order; there is no loss or duplication.

Reset
REQ-027 With reset=1 at an edge: the FIFO is emptied, with out_valid=0, instruction=0, count=0 and imm_err=0; in_ready=1 the following cycle.
REQ-028 Reset mid-operation discards buffered words without delivering them; in_valid and out_ready are ignored during reset cycles.

Configuration
REQ-029 The macro IMM_RANGE_CHECK_EN SHALL compile the range check in or out.
REQ-030 Defined: an accepted field set is out of range when imm[63:12] is not all equal to imm[11]. Such a set is consumed but not pushed, and imm_err pulses high for the cycle after acceptance.
REQ-031 Undefined: imm is silently truncated per REQ-014 to REQ-016, every accepted set is pushed, and imm_err is tied to 0.

Verification
REQ-032 I-type: opcode=0000011, rd=5, funct3=3, rs1=2, imm=-8 -> instruction=0xFF813283 one cycle after accept; count=1 after the pop.
REQ-033 S-type: opcode=0100011, funct3=3, rs1=2, rs2=5, imm=16 -> instruction=0x00513823.
REQ-034 SB-type: opcode=1100011, funct3=0, rs1=1, rs2=2, imm=4 -> instruction=0x00208463; re-extraction yields 4.
REQ-035 Backpressure: out_ready=0 with 3 back-to-back offers -> in_ready=0 after 2 accepts; then out_ready=1 -> 3 words delivered in order and count=3.
REQ-036 Range, I-type fields of REQ-032 with imm=0x800:
- macro defined -> no word produced, imm_err=1 for one cycle, count unchanged;
- macro undefined -> instruction=0x80013283.
REQ-037 Reset with 2 words buffered and out_ready=0 -> next cycle out_valid=0, count=0, in_ready=1; no buffered word ever appears.

Source files
------------

// File: rtl/instruction_encoder.sv
// Field-set to 32-bit instruction encoder (I / S / SB formats) with a 2-entry output FIFO.
// Optional immediate range check compiled in with `define IMM_RANGE_CHECK_EN.
module instruction_encoder (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic [63:0] imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] instruction,
  output logic [15:0] count,
  output logic        imm_err
);

  typedef struct packed {
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [11:0] imm;
  } fields_t;

  function automatic logic [31:0] encode(input fields_t f);
    logic [31:0] w;
    case (f.opcode[6:5])
      2'b00:   w = {f.imm[11:0], f.rs1, f.funct3, f.rd, f.opcode};
      2'b01:   w = {f.imm[11:5], f.rs2, f.rs1, f.funct3, f.imm[4:0], f.opcode};
      default: w = {f.imm[11], f.imm[9:4], f.rs2, f.rs1, f.funct3, f.imm[3:0], f.imm[10], f.opcode};
    endcase
    return w;
  endfunction

  fields_t          req;
  logic [1:0][31:0] mem;
  logic             wptr, rptr;
  logic [1:0]       occ;
  logic             accept, push, pop, imm_ok;
  logic [31:0]      word;

  assign req  = '{opcode: opcode, rd: rd, rs1: rs1, rs2: rs2, funct3: funct3, imm: imm[11:0]};
  assign word = encode(req);

`ifdef IMM_RANGE_CHECK_EN
  assign imm_ok = (imm[63:12] == {52{imm[11]}});
`else
  // Upper immediate bits are truncated silently in this build.
  logic unused_imm_hi;
  assign unused_imm_hi = ^imm[63:12];
  assign imm_ok = 1'b1;
`endif

  assign in_ready    = (occ != 2'd2);
  assign out_valid   = (occ != 2'd0);
  assign instruction = mem[rptr];
  assign accept      = in_valid && in_ready;
  assign push        = accept && imm_ok;
  assign pop         = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      mem   <= '0;
      wptr  <= 1'b0;
      rptr  <= 1'b0;
      occ   <= 2'd0;
      count <= 16'd0;
    end else begin
      if (push) begin
        mem[wptr] <= word;
        wptr      <= ~wptr;
      end
      if (pop) begin
        rptr  <= ~rptr;
        count <= count + 16'd1;
      end
      occ <= occ + {1'b0, push} - {1'b0, pop};
    end
  end

`ifdef IMM_RANGE_CHECK_EN
  always_ff @(posedge clk) begin
    if (reset) imm_err <= 1'b0;
    else       imm_err <= accept && !imm_ok;
  end
`else
  assign imm_err = 1'b0;
`endif

endmodule

// File: tb/tb_instruction_encoder.sv
// Self-checking bench for instruction_encoder: directed vectors plus randomized traffic
// checked against a queue-based reference model.
module tb_instruction_encoder;
  logic        clk = 1'b0, reset = 1'b1, in_valid = 1'b0, out_ready = 1'b0;
  logic        in_ready, out_valid, imm_err;
  logic [6:0]  opcode = '0;
  logic [4:0]  rd = '0, rs1 = '0, rs2 = '0;
  logic [2:0]  funct3 = '0;
  logic [63:0] imm = '0;
  logic [31:0] instruction;
  logic [15:0] count;

  instruction_encoder dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3), .imm(imm),
    .out_valid(out_valid), .out_ready(out_ready), .instruction(instruction),
    .count(count), .imm_err(imm_err)
  );

  always #5 clk = ~clk;

`ifdef IMM_RANGE_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif

  typedef struct {
    logic [31:0] word;
    logic [63:0] imm;
    bit          ok;
  } ent_t;

  ent_t        q[$];
  int unsigned cnt_m = 0;
  bit          err_m = 1'b0;
  int          tests = 0, fails = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic bit in_range(input logic [63:0] v);
    return ($signed(v) >= -64'sd2048) && ($signed(v) <= 64'sd2047);
  endfunction

  // Instruction word built from field positions with shifts and masks.
  function automatic logic [31:0] enc(input logic [6:0] op, input logic [4:0] d, input logic [2:0] f3,
                                      input logic [4:0] s1, input logic [4:0] s2, input logic [63:0] iv);
    logic [31:0] i12, w;
    i12 = iv[31:0] & 32'hFFF;
    w   = 32'(op) | (32'(f3) << 12) | (32'(s1) << 15);
    if (op[6])      w = w | (32'(s2) << 20) | (((i12 >> 10) & 1) << 7) | ((i12 & 15) << 8)
                          | (((i12 >> 4) & 63) << 25) | (((i12 >> 11) & 1) << 31);
    else if (op[5]) w = w | (32'(s2) << 20) | ((i12 & 31) << 7) | ((i12 >> 5) << 25);
    else            w = w | (32'(d) << 7) | (i12 << 20);
    return w;
  endfunction

  function automatic logic [63:0] extract(input logic [31:0] w);
    logic [11:0] v;
    if (w[6])      v = {w[31], w[7], w[30:25], w[11:8]};
    else if (w[5]) v = {w[31:25], w[11:7]};
    else           v = w[31:20];
    return {{52{v[11]}}, v};
  endfunction

  // One clock: check handshake outputs and the head word, advance model across the edge.
  task automatic cycle();
    bit   acc, pop;
    ent_t e;
    if (!reset) begin
      chk("in_ready", in_ready, q.size() < 2);
      chk("out_valid", out_valid, q.size() != 0);
    end
    acc = !reset && in_valid && (q.size() < 2);
    pop = !reset && out_ready && (q.size() != 0);
    if (pop) begin
      chk("instr", instruction, q[0].word);
      if (q[0].ok) chk("roundtrip", extract(instruction), q[0].imm);
    end
    e.word = enc(opcode, rd, funct3, rs1, rs2, imm);
    e.imm  = imm;
    e.ok   = in_range(imm);
    @(posedge clk);
    #1;
    if (reset) begin
      q.delete();
      cnt_m = 0;
      err_m = 1'b0;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_instr", instruction, 0);
      chk("rst_in_ready", in_ready, 1);
    end else begin
      if (pop) begin
        void'(q.pop_front());
        cnt_m = (cnt_m + 1) % 65536;
      end
      err_m = 1'b0;
      if (acc) begin
        if (e.ok || !CHECK_EN) q.push_back(e);
        else err_m = 1'b1;
      end
    end
    chk("count", count, cnt_m);
    chk("imm_err", imm_err, err_m);
  endtask

  task automatic set_fields(input logic [6:0] op, input logic [4:0] d, input logic [2:0] f3,
                            input logic [4:0] s1, input logic [4:0] s2, input logic [63:0] iv);
    opcode = op; rd = d; funct3 = f3; rs1 = s1; rs2 = s2; imm = iv;
  endtask

  task automatic send_one();
    in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
  endtask

  initial begin
    int unsigned base;
    int          guard;
    #1;
    reset = 1'b1;
    cycle();
    cycle();
    reset = 1'b0;

    // I-type
    set_fields(7'b0000011, 5, 3, 2, 0, -64'sd8);
    send_one();
    chk("i_word", instruction, 32'hFF813283);
    chk("i_valid", out_valid, 1);
    out_ready = 1'b1; cycle(); out_ready = 1'b0;
    chk("i_count", count, 1);

    // S-type
    set_fields(7'b0100011, 0, 3, 2, 5, 64'd16);
    send_one();
    chk("s_word", instruction, 32'h00513823);
    out_ready = 1'b1; cycle(); out_ready = 1'b0;

    // SB-type
    set_fields(7'b1100011, 9, 0, 1, 2, 64'd4);
    send_one();
    chk("sb_word", instruction, 32'h00208463);
    chk("sb_extract", extract(instruction), 64'd4);
    out_ready = 1'b1; cycle(); out_ready = 1'b0;

    // Backpressure: three back-to-back offers against a stalled sink
    base = cnt_m;
    in_valid = 1'b1;
    set_fields(7'b0000011, 1, 0, 1, 0, 64'd1); cycle();
    set_fields(7'b0000011, 2, 0, 2, 0, 64'd2); cycle();
    chk("bp_full", in_ready, 0);
    set_fields(7'b0000011, 3, 0, 3, 0, 64'd3); cycle();
    out_ready = 1'b1;
    cycle();
    chk("bp_ready_rise", in_ready, 1);
    cycle();
    in_valid = 1'b0;
    guard = 0;
    while (q.size() != 0 && guard < 20) begin cycle(); guard++; end
    chk("bp_drain_timeout", guard < 20, 1);
    chk("bp_count", count, 16'(base + 3));
    out_ready = 1'b0;

    // Out-of-range immediate
    base = cnt_m;
    set_fields(7'b0000011, 5, 3, 2, 0, 64'h800);
    send_one();
`ifdef IMM_RANGE_CHECK_EN
    chk("rng_err", imm_err, 1);
    chk("rng_novalid", out_valid, 0);
    cycle();
    chk("rng_err_clear", imm_err, 0);
    chk("rng_count", count, 16'(base));
`else
    chk("rng_trunc", instruction, 32'h80013283);
    out_ready = 1'b1; cycle(); out_ready = 1'b0;
`endif

    // Reset with two words buffered
    set_fields(7'b0100011, 0, 1, 4, 6, 64'd7); send_one();
    set_fields(7'b0100011, 0, 2, 5, 7, 64'd9); send_one();
    reset = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    cycle();
    reset = 1'b0; in_valid = 1'b0;
    chk("rst_count", count, 0);
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("rst_no_word", out_valid, 0);
    end

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      logic [11:0] s12;
      s12 = 12'($urandom);
      opcode = 7'($urandom); rd = 5'($urandom); rs1 = 5'($urandom);
      rs2 = 5'($urandom); funct3 = 3'($urandom);
      if ($urandom_range(0, 7) == 0) imm = {32'($urandom), 32'($urandom)};
      else                           imm = {{52{s12[11]}}, s12};
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      reset     = ($urandom_range(0, 199) == 0);
      cycle();
    end
    reset = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
